// File: rtl/ysyx_22040895_immgen_pkg.sv
// Shared definitions for the immediate generator: format codes and buffer states.
package ysyx_22040895_immgen_pkg;

  typedef enum logic [2:0] {
    FmtI = 3'd0,
    FmtS = 3'd1,
    FmtB = 3'd2,
    FmtU = 3'd3,
    FmtJ = 3'd4,
    FmtZ = 3'd5
  } ysyx_22040895_fmt_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } ysyx_22040895_state_e;

  localparam int unsigned ysyx_22040895_FmtWidth = 3;

endpackage

// File: rtl/ysyx_22040895_immdec.sv
// Combinational immediate decode and extension for RV formats I/S/B/U/J and CSR uimm.
module ysyx_22040895_immdec
  import ysyx_22040895_immgen_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned INSTLEN = 32
) (
  input  logic [INSTLEN-1:0]              inst_i,
  input  logic [ysyx_22040895_FmtWidth-1:0] fmt_i,
  output logic [XLEN-1:0]                 imm_o,
  output logic                            err_o
);

  logic [31:0] ins;
  logic [31:0] raw;
  logic        unused_opcode;

  assign ins           = inst_i[31:0];
  assign unused_opcode = ^ins[6:0];

  // Every format is first sign-extended to 32 bits; Z has a zero top bit so the
  // common widening below zero-extends it.
  always_comb begin
    raw   = '0;
    err_o = 1'b0;
    case (fmt_i)
      FmtI:    raw = {{20{ins[31]}}, ins[31:20]};
      FmtS:    raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FmtB:    raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FmtU:    raw = {ins[31:12], 12'b0};
      FmtJ:    raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FmtZ:    raw = {27'b0, ins[19:15]};
      default: err_o = 1'b1;
    endcase
  end

  if (XLEN > 32) begin : g_ext
    assign imm_o = {{(XLEN-32){raw[31]}}, raw};
  end else begin : g_narrow
    assign imm_o = raw[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22040895_immgen.sv
// Immediate generator with a registered 2-entry output buffer and valid/ready handshakes.
module ysyx_22040895_immgen
  import ysyx_22040895_immgen_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned INSTLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTLEN-1:0] inst_i,
  input  logic [2:0]         fmt_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    imm_o,
  output logic               err_o
);

  ysyx_22040895_state_e state_q, state_d;
  logic                 in_ready_q;
  logic [XLEN-1:0]      imm0_q, imm0_d, imm1_q, imm1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_err;
  logic                 push, pop, push_ok;

  ysyx_22040895_immdec #(
    .XLEN    (XLEN),
    .INSTLEN (INSTLEN)
  ) u_immdec (
    .inst_i (inst_i),
    .fmt_i  (fmt_i),
    .imm_o  (dec_imm),
    .err_o  (dec_err)
  );

  assign push    = in_valid_i && in_ready_q;
  assign pop     = out_valid_o && out_ready_i;
  assign push_ok = push && !flush_i;

  always_comb begin
    state_d = state_q;
    imm0_d  = imm0_q;
    err0_d  = err0_q;
    imm1_d  = imm1_q;
    err1_d  = err1_q;
    case (state_q)
      StEmpty: begin
        if (push) state_d = StOne;
        if (push_ok) begin
          imm0_d = dec_imm;
          err0_d = dec_err;
        end
      end
      StOne: begin
        if (push && !pop) state_d = StFull;
        else if (!push && pop) state_d = StEmpty;
        // Slot 0 is always the head; a simultaneous pop lets the new entry take it.
        if (push_ok && pop) begin
          imm0_d = dec_imm;
          err0_d = dec_err;
        end else if (push_ok) begin
          imm1_d = dec_imm;
          err1_d = dec_err;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StOne;
          imm0_d  = imm1_q;
          err0_d  = err1_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush_i) state_d = StEmpty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      imm0_q     <= '0;
      err0_q     <= 1'b0;
      imm1_q     <= '0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
      imm0_q     <= imm0_d;
      err0_q     <= err0_d;
      imm1_q     <= imm1_d;
      err1_q     <= err1_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign imm_o       = imm0_q;
  assign err_o       = err0_q;

endmodule

// File: tb/tb_ysyx_22040895_immgen.sv
// Directed bench for the immediate generator: decode table plus buffer/flush/reset sequences.
module tb_ysyx_22040895_immgen;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [2:0]  fmt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm;
  logic        err;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] inst32;
  logic [2:0]  fmt32;
  logic        out_valid32;
  logic [31:0] imm32;
  logic        err32;

  int checks;
  int errors;

  ysyx_22040895_immgen #(.XLEN(64), .INSTLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .inst_i      (inst),
    .fmt_i       (fmt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .imm_o       (imm),
    .err_o       (err)
  );

  ysyx_22040895_immgen #(.XLEN(32), .INSTLEN(32)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (1'b0),
    .in_valid_i  (in_valid32),
    .in_ready_o  (in_ready32),
    .inst_i      (inst32),
    .fmt_i       (fmt32),
    .out_valid_o (out_valid32),
    .out_ready_i (1'b1),
    .imm_o       (imm32),
    .err_o       (err32)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] f);
    in_valid = 1'b1;
    inst     = i;
    fmt      = f;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h00500093, 3'd0, 64'h0000000000000005, 1'b0};
    vecs[2]  = '{32'h00A12423, 3'd1, 64'h0000000000000008, 1'b0};
    vecs[3]  = '{32'hFE000FA3, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[4]  = '{32'h80000063, 3'd2, 64'hFFFFFFFFFFFFF000, 1'b0};
    vecs[5]  = '{32'h00208463, 3'd2, 64'h0000000000000008, 1'b0};
    vecs[6]  = '{32'hABCDE037, 3'd3, 64'hFFFFFFFFABCDE000, 1'b0};
    vecs[7]  = '{32'h0080006F, 3'd4, 64'h0000000000000008, 1'b0};
    vecs[8]  = '{32'hFFDFF06F, 3'd4, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[9]  = '{32'h000F8073, 3'd5, 64'h000000000000001F, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 3'd7, 64'h0000000000000000, 1'b1};

    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    inst = '0;
    fmt = '0;
    out_ready = 1'b1;
    in_valid32 = 1'b0;
    inst32 = '0;
    fmt32 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset imm", imm, 64'd0);
    chk("reset err", 64'(err), 64'd0);

    // Decode table: one push, check one cycle later, then let it drain.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].inst, vecs[i].fmt);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d imm", i), imm, vecs[i].imm);
      chk($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].err));
      step();
      chk($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
    end
    drive(32'h0, 3'd6);
    step();
    in_valid = 1'b0;
    chk("fmt6 imm", imm, 64'd0);
    chk("fmt6 err", 64'(err), 64'd1);
    step();

    // Backpressure: three back-to-back pushes, only two fit.
    out_ready = 1'b0;
    drive(32'h00500093, 3'd0);
    step();
    chk("bp1 in_ready", 64'(in_ready), 64'd1);
    chk("bp1 imm", imm, 64'd5);
    drive(32'h00A12423, 3'd1);
    step();
    chk("bp2 in_ready", 64'(in_ready), 64'd0);
    chk("bp2 imm", imm, 64'd5);
    drive(32'hFFF00093, 3'd0);
    step();
    chk("bp3 in_ready", 64'(in_ready), 64'd0);
    chk("bp3 imm hold", imm, 64'd5);
    chk("bp3 out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp pop1 imm", imm, 64'd8);
    chk("bp pop1 in_ready", 64'(in_ready), 64'd1);
    step();
    chk("bp pop2 out_valid", 64'(out_valid), 64'd0);

    // ONE with simultaneous push and pop.
    drive(32'h00500093, 3'd0);
    step();
    chk("pp first imm", imm, 64'd5);
    drive(32'hFFF00093, 3'd0);
    step();
    in_valid = 1'b0;
    chk("pp out_valid", 64'(out_valid), 64'd1);
    chk("pp imm", imm, 64'hFFFFFFFFFFFFFFFF);
    chk("pp in_ready", 64'(in_ready), 64'd1);
    step();
    chk("pp drained", 64'(out_valid), 64'd0);

    // Flush from FULL with a push, then from ONE with a push.
    out_ready = 1'b0;
    drive(32'h00500093, 3'd0);
    step();
    drive(32'h00A12423, 3'd1);
    step();
    chk("fl full in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(32'hFFF00093, 3'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl full out_valid", 64'(out_valid), 64'd0);
    chk("fl full in_ready after", 64'(in_ready), 64'd1);
    drive(32'h00500093, 3'd0);
    step();
    chk("fl one out_valid before", 64'(out_valid), 64'd1);
    flush = 1'b1;
    drive(32'h00A12423, 3'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl one out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    drive(32'hFFDFF06F, 3'd4);
    step();
    in_valid = 1'b0;
    chk("fl recover imm", imm, 64'hFFFFFFFFFFFFFFFC);
    step();
    chk("fl recover drained", 64'(out_valid), 64'd0);

    // Reset mid-stream with a concurrent push.
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd0);
    step();
    drive(32'h000F8073, 3'd5);
    step();
    rst = 1'b0;
    drive(32'h00500093, 3'd0);
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    chk("rst full out_valid", 64'(out_valid), 64'd0);
    chk("rst full in_ready", 64'(in_ready), 64'd1);
    chk("rst full imm", imm, 64'd0);
    drive(32'h0, 3'd7);
    step();
    in_valid = 1'b0;
    chk("rst pre err", 64'(err), 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst one err", 64'(err), 64'd0);
    chk("rst one out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    chk("rst idle imm", imm, 64'd0);
    chk("rst idle err", 64'(err), 64'd0);

    // Narrow instance.
    in_valid32 = 1'b1;
    inst32 = 32'hABCDE037;
    fmt32 = 3'd3;
    step();
    in_valid32 = 1'b0;
    chk("x32 out_valid", 64'(out_valid32), 64'd1);
    chk("x32 imm", 64'(imm32), 64'h00000000ABCDE000);
    chk("x32 err", 64'(err32), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
